// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-image loader.
// Frame: LEN_HI, LEN_LO, N x (HI, LO), CHK (XOR of all preceding bytes).
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W     = 8;
    localparam int LEN_MAX    = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams a length/payload/checksum framed image into instruction memory and
// holds the core until a checksum-verified image is in place.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_hold
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic                w_rdy;
    logic                w_acc;
    logic                w_start_ok;
    logic                w_wr;
    logic [15:0]         w_len16;
    logic [ADDR_W:0]     w_cnt_inc;
    logic [DATA_W-1:0]   w_word;

    logic [BYTE_W-1:0]   r_len_hi;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_cnt;
    logic [BYTE_W-1:0]   r_hi;
    logic [BYTE_W-1:0]   r_xor;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_adr;
    logic [DATA_W-1:0]   r_mem_wdata;

    assign w_len16   = {r_len_hi, in_byte};
    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_word    = {r_hi, in_byte};

    always_comb begin
        w_next     = r_state;
        w_rdy      = 1'b0;
        w_start_ok = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                w_start_ok = start;
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_rdy = 1'b1;
                if (in_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_rdy = 1'b1;
                if (in_valid) begin
                    if (w_len16 > 16'(LEN_MAX))  w_next = S_ERR;
                    else if (w_len16 == 16'd0)   w_next = S_CHECK;
                    else                          w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                w_rdy = 1'b1;
                if (in_valid) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                w_rdy = 1'b1;
                if (in_valid) w_next = (w_cnt_inc == r_len) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                w_rdy = 1'b1;
                if (in_valid) w_next = (in_byte == r_xor) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_acc = in_valid & w_rdy;
    assign w_wr  = w_acc & (r_state == S_DATA_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_hi    <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_xor       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_wr;
            if (w_start_ok) begin
                r_xor <= '0;
                r_cnt <= '0;
            end else if (w_acc && r_state != S_CHECK) begin
                r_xor <= r_xor ^ in_byte;
            end
            if (w_acc && r_state == S_LEN_HI)  r_len_hi <= in_byte;
            // Only loaded when in range, so the truncation to the counter width is exact.
            if (w_acc && r_state == S_LEN_LO)  r_len <= w_len16[ADDR_W:0];
            if (w_acc && r_state == S_DATA_HI) r_hi <= in_byte;
            if (w_wr) begin
                r_mem_adr   <= r_cnt[ADDR_W-1:0];
                r_mem_wdata <= w_word;
                r_cnt       <= w_cnt_inc;
            end
        end
    end

    assign in_ready  = w_rdy;
    assign busy      = w_rdy;
    assign mem_we    = r_mem_we;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign core_hold = (r_state != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized directed bench for prog_loader: frames are built from word lists,
// and writes are checked against the word list the frame was built from.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_adr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_hold;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_hold (core_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] words_q[$];
    logic [7:0]  frame_q[$];
    logic [25:0] wr_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back({mem_adr, mem_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Header value, payload from words_q, XOR checksum (optionally corrupted).
    task automatic make_frame(input int n_hdr, input bit bad_chk);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(8'((n_hdr >> 8) & 255));
        frame_q.push_back(8'(n_hdr & 255));
        foreach (words_q[k]) begin
            frame_q.push_back(words_q[k][15:8]);
            frame_q.push_back(words_q[k][7:0]);
        end
        x = 8'h00;
        foreach (frame_q[k]) x = x ^ frame_q[k];
        if (bad_chk) x = x ^ 8'h01;
        frame_q.push_back(x);
    endtask

    // Entered and left on a falling edge; returns on the falling edge after the accept.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int tmo;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        tmo = 0;
        while (in_ready !== 1'b1 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (in_ready !== 1'b1) chk("rdy_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int first, input int last_excl, input int maxgap);
        int nw;
        nw = words_q.size();
        for (int i = first; i < last_excl; i++) begin
            send_byte(frame_q[i], maxgap);
            if (i >= 3 && (i % 2) == 1 && i <= 2 * nw + 1) begin
                chk("we_lo", 32'(mem_we), 32'd1);
                chk("adr_lo", 32'(mem_adr), 32'((i - 3) / 2));
                chk("dat_lo", 32'(mem_wdata), 32'(words_q[(i - 3) / 2]));
            end else begin
                chk("we_other", 32'(mem_we), 32'd0);
            end
        end
    endtask

    task automatic check_writes();
        int n;
        chk("wr_count", 32'(wr_q.size()), 32'(words_q.size()));
        n = (wr_q.size() < words_q.size()) ? wr_q.size() : words_q.size();
        for (int k = 0; k < n; k++) begin
            chk("wr_adr", 32'(wr_q[k][25:16]), 32'(k));
            chk("wr_dat", 32'(wr_q[k][15:0]), 32'(words_q[k]));
        end
    endtask

    task automatic do_start();
        wr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_rdy", 32'(in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
    endtask

    task automatic chk_end(input string tag, input logic d, input logic e);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_hold"}, 32'(core_hold), 32'(!d));
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_adr"}, 32'(mem_adr), 32'd0);
        chk({tag, "_dat"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        #3;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", 32'(in_ready), 32'd0);
        chk("idle_hold", 32'(core_hold), 32'd1);

        // Good two-word load: 00 02 80 40 12 34 E4
        words_q = '{16'h8040, 16'h1234};
        make_frame(2, 1'b0);
        chk("chk_byte", 32'(frame_q[6]), 32'hE4);
        do_start();
        run_frame(0, 7, 0);
        chk_end("good", 1'b1, 1'b0);
        check_writes();

        // Bad checksum: writes still land, then a good reload recovers.
        make_frame(2, 1'b1);
        do_start();
        run_frame(0, 7, 0);
        chk_end("badchk", 1'b0, 1'b1);
        check_writes();
        make_frame(2, 1'b0);
        do_start();
        run_frame(0, 7, 1);
        chk_end("reload", 1'b1, 1'b0);
        check_writes();

        // Empty image.
        words_q.delete();
        make_frame(0, 1'b0);
        do_start();
        run_frame(0, 3, 0);
        chk_end("empty", 1'b1, 1'b0);
        check_writes();

        // Oversize length 0x0401, then re-arm and finish with an empty frame.
        make_frame(1025, 1'b0);
        do_start();
        run_frame(0, 2, 0);
        chk_end("oversize", 1'b0, 1'b1);
        check_writes();
        make_frame(0, 1'b0);
        do_start();
        run_frame(0, 3, 0);
        chk_end("rearm", 1'b1, 1'b0);
        check_writes();

        // Full 1024-word image with random valid gaps.
        words_q.delete();
        for (int k = 0; k < 1024; k++) words_q.push_back(16'($urandom));
        make_frame(1024, 1'b0);
        do_start();
        run_frame(0, frame_q.size(), 3);
        chk_end("full", 1'b1, 1'b0);
        check_writes();

        // Reset while word 5's LO byte is pending.
        words_q.delete();
        for (int k = 0; k < 8; k++) words_q.push_back(16'($urandom));
        make_frame(8, 1'b0);
        do_start();
        run_frame(0, 13, 1);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_writes", 32'(wr_q.size()), 32'd5);
        chk("midrst_idle_rdy", 32'(in_ready), 32'd0);

        // start in the middle of a frame must not restart it.
        words_q.delete();
        for (int k = 0; k < 3; k++) words_q.push_back(16'($urandom));
        make_frame(3, 1'b0);
        do_start();
        run_frame(0, 5, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_busy", 32'(busy), 32'd1);
        run_frame(5, frame_q.size(), 1);
        chk_end("ignstart", 1'b1, 1'b0);
        check_writes();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that streams a 16-bit instruction image into the 1024-word instruction memory before the pipelined datapath runs. It is the write side of the instruction memory, which the fetch stage only reads. Bytes arrive on a valid/ready stream and are framed as length, payload and checksum. The loader produces single-cycle memory write strobes and holds the core until a complete, checksum-verified image is in place.

## Interface
Parameters:
- ADDR_W, 10, instruction memory address width (1024 words)
- DATA_W, 16, instruction width

Ports:
- clk  in  1  system clock; the single clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  stream byte valid
- in_byte  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe
- mem_adr  out  ADDR_W  write address (word index)
- mem_wdata  out  DATA_W  write data
- busy  out  1  a load is in progress
- done  out  1  level; last load completed with a good checksum
- err  out  1  level; last load failed
- core_hold  out  1  stall/hold request to the datapath

## Operation
- **Handshake:** a byte is accepted when in_valid & in_ready. Throughput is 1 byte/cycle, and in_valid may gap arbitrarily.
- **Frame format:** all multi-byte fields are big-endian, in this order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words, each sent as a HI byte then a LO byte.
  - One CHK byte, equal to the XOR of every preceding byte of the frame.
- **States:** IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- **Transitions:**
  - IDLE/DONE/ERR + start -> LEN_HI. This clears the running XOR and the word counter, and drops done/err.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO -> on accept:
    - ERR if N > 1024.
    - CHECK if N = 0.
    - DATA_HI otherwise.
  - DATA_HI -> DATA_LO on accept; the byte is latched as the upper half of the word.
  - DATA_LO -> on accept:
    - A memory write is issued.
    - The word counter increments.
    - Next state is CHECK if the counter reaches N, otherwise DATA_HI.
  - CHECK -> on accept: DONE if the byte equals the running XOR, ERR otherwise.
- **start while busy:** ignored.
- **in_ready:** 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- **busy:** 1 in the same states as in_ready.
- **core_hold:** 1 in every state except DONE, including after reset. The core never runs on a partial or bad image.
- **Failed loads:** memory writes are not rolled back on ERR.
- **Word counter:** 11 bits, so N = 1024 is reachable. mem_adr takes the low 10 bits; the last address is 1023 and it never wraps.
- **Running XOR:** updated on every accepted byte except CHK.

## Timing
- **Reset values:**
  - State IDLE.
  - in_ready, busy, done, err and mem_we = 0.
  - mem_adr and mem_wdata = 0.
  - core_hold = 1.
- **Memory write:** mem_we is registered. It is high for exactly 1 cycle, the cycle after the DATA_LO accept, with mem_adr/mem_wdata valid in that same cycle. mem_adr/mem_wdata hold their values otherwise.
- **done/err:** rise the cycle after the CHK accept, or the cycle after the LEN_LO accept for oversize N. They stay high until the next honoured start or rst.
- **core_hold:** falls in the same cycle done rises.
- **start latency:** in_ready rises the cycle after start.
- **Write vs. next byte:** a DATA_LO accept and the next DATA_HI accept may occur in consecutive cycles. The memory write overlaps the DATA_HI accept, and there is no stall.
- **Reset mid-load:** asynchronous return to IDLE with reset values. Memory contents are untouched.

## Structure
- **Package prog_loader_pkg:**
  - State enum.
  - LEN_MAX = 1024.
  - ADDR_W and DATA_W defaults.
  - Byte width 8.
- **Modules:** a single module with no sub-module. The FSM, byte latch, counter and XOR accumulator are small enough to keep flat.

## Test plan
- **Good load:** start, then bytes 00 02 80 40 12 34 E4 -> writes adr0=0x8040 and adr1=0x1234. done=1 and core_hold=0 the cycle after E4. err=0.
- **Bad checksum:** same frame with CHK = E5 -> both writes still occur. err=1, done=0, core_hold stays 1. A following start with the good frame then yields done=1.
- **Empty image:** bytes 00 00 00 -> no mem_we. done=1 after the third byte.
- **Oversize length:** bytes 04 01 -> err=1 the cycle after 01, in_ready=0, no writes. start re-arms the loader.
- **Full image with gaps:** N = 1024 (04 00), random in_valid gaps -> 1024 writes at adr 0..1023 in order, one mem_we per word, done=1 with the correct CHK.
- **Reset and start during a load:** rst asserted during DATA_LO of word 5 -> outputs take reset values immediately and in_ready=0. start asserted mid-frame is ignored.
